instr_seq_ctrl: RTL
===================

// Module: instr_seq_ctrl
// PURPOSE
//  Multi-cycle fetch/decode/dispatch sequencer driving the 8-bit program counter (en/model_sel/load_value) and RAM read.
//  Fetches opcode bytes, fetches jump-operand bytes, and redirects the PC on taken jumps.
//  Dispatches all other opcodes to the datapath via a valid/ready handshake.
//  Sits between the PC counter, program RAM and the ALU/register datapath.
// PARAMETERS
//  MEM_LAT      1   RAM read latency in cycles, legal range 1..15: mem_rdata valid MEM_LAT cycles after the mem_rd cycle
//  WDOG_CYCLES  16  exec handshake timeout in cycles, legal range 1..255; used only with SEQ_WATCHDOG_EN
// PORTS
//  clk            in   1  clock, rising edge
//  reset          in   1  asynchronous, active-high reset
//  start          in   1  level-sampled: leaves IDLE/HALT
//  mem_rdata      in   8  RAM read data; the address is the PC value
//  zero_flag      in   1  datapath Z flag, sampled in JUMP
//  exec_ready     in   1  datapath accepts the dispatched instruction
//  mem_rd         out  1  RAM read strobe
//  pc_en          out  1  to PC en
//  pc_load        out  1  to PC model_sel: 1 = load, 0 = increment
//  pc_load_value  out  8  to PC load_value
//  ir             out  8  instruction register
//  exec_valid     out  1  ir holds an instruction for the datapath
//  halted         out  1  sequencer is in HALT
//  fault          out  1  watchdog fault; constant 0 without SEQ_WATCHDOG_EN
// BEHAVIOUR
//  Reset
//   - Async; state=IDLE; every output and internal register (ir, target, counters) = 0.
//   - Mid-operation reset aborts at once; no pending fetch or dispatch survives.
//  Opcode = ir[7:4]
//   - 0x0 NOP; 0xF HLT.
//   - 0x8 JMP and 0x9 JZ are two-byte: opcode byte, then target byte.
//   - All other opcodes dispatch to the datapath.
//  States; outputs are 0 unless listed
//   - IDLE: start=1 -> FETCH.
//   - FETCH: mem_rd=1 for 1 cycle -> WAIT.
//   - WAIT: lasts MEM_LAT cycles. In the last cycle: ir<=mem_rdata, pc_en=1, pc_load=0 (PC+1) -> DECODE.
//   - DECODE: 1 cycle.
//       NOP -> FETCH; HLT -> HALT; JMP/JZ -> FETCH_OP; else -> EXEC.
//   - FETCH_OP: mem_rd=1 -> WAIT_OP.
//   - WAIT_OP: same as WAIT, but target<=mem_rdata -> JUMP.
//   - JUMP: taken = JMP | (JZ & zero_flag).
//       Taken: pc_en=1, pc_load=1, pc_load_value=target for exactly 1 cycle.
//       Not taken: PC untouched, already past the operand.
//       -> FETCH.
//   - EXEC: exec_valid=1 with ir stable.
//       exec_valid&&exec_ready at a clock edge -> FETCH.
//       exec_valid never drops before the handshake.
//   - HALT: halted=1. start=1 -> FETCH, resuming at the current PC (the byte after HLT).
//  Timing and boundary rules
//   - start is ignored outside IDLE/HALT.
//   - pc_load_value is 0 whenever pc_load=0.
//   - Per-instruction cost, cycles:
//       NOP 2+MEM_LAT; HLT 2+MEM_LAT to halted=1.
//       JMP/JZ 4+2*MEM_LAT.
//       EXEC 3+MEM_LAT+exec stall.
//   - PC wrap 0xFF->0x00 is the counter's; a JMP opcode at 0xFF fetches its operand from 0x00.
//   - pc_en and mem_rd are never high in the same cycle.
//   - pc_load=1 only in JUMP.
// CONFIGURATION
//  SEQ_WATCHDOG_EN defined
//   - 8-bit counter clears on EXEC entry and counts EXEC cycles.
//   - WDOG_CYCLES cycles without exec_ready: exec_valid drops, fault=1, -> HALT.
//   - fault is sticky until reset; start is ignored while fault=1.
//  Not defined
//   - EXEC waits indefinitely; fault is tied to 0.
// TESTING
//  1 Reset mid-WAIT -> all outputs 0 in the same cycle; IDLE; no pc_en pulse after reset release until start.
//  2 MEM_LAT=1, RAM[0]=0x00, RAM[1]=0xF0, start -> mem_rd at cycles 1 and 4, pc_en at 2 and 5, halted=1 at cycle 7.
//  3 RAM[0..1]=0x80,0x20 -> single pc_en&pc_load cycle with pc_load_value=0x20; next mem_rd is at PC=0x20.
//  4 RAM[0..1]=0x90,0x40: Z=0 -> next fetch at PC=0x02; Z=1 -> next fetch at 0x40.
//  5 RAM[0]=0x35, exec_ready held low 5 cycles -> exec_valid=1 and ir=0x35 stable throughout; FETCH follows the handshake.
//  6 SEQ_WATCHDOG_EN, WDOG_CYCLES=4, exec_ready=0 -> after 4 EXEC cycles fault=1, halted=1; start ignored.

Source files
------------

// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: fetch/decode/dispatch sequencer for an 8-bit program counter and program RAM.
//
// Fetches an opcode byte, then a target byte for JMP (0x8) and JZ (0x9). Taken jumps load the
// PC. NOP (0x0) goes straight to the next fetch and HLT (0xF) parks the sequencer. Every other
// opcode is handed to the datapath with a valid/ready handshake.
//
// Optional feature: define SEQ_WATCHDOG_EN to enable the EXEC handshake watchdog. Without it,
// EXEC waits indefinitely and fault is tied to 0.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   start          in   level-sampled; leaves IDLE or HALT
//   mem_rdata[7:0] in   RAM read data, addressed by the PC
//   zero_flag      in   datapath Z flag, sampled in JUMP
//   exec_ready     in   datapath accepts the dispatched instruction
//   mem_rd         out  RAM read strobe
//   pc_en          out  PC enable
//   pc_load        out  PC mode select: 1 = load, 0 = increment
//   pc_load_value  out  PC load value; 0 whenever pc_load is 0
//   ir[7:0]        out  instruction register
//   exec_valid     out  ir holds an instruction for the datapath
//   halted         out  sequencer is in HALT
//   fault          out  sticky watchdog fault

module instr_seq_ctrl #(
  parameter int unsigned MEM_LAT     = 1,
  parameter int unsigned WDOG_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] mem_rdata,
  input  logic       zero_flag,
  input  logic       exec_ready,
  output logic       mem_rd,
  output logic       pc_en,
  output logic       pc_load,
  output logic [7:0] pc_load_value,
  output logic [7:0] ir,
  output logic       exec_valid,
  output logic       halted,
  output logic       fault
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("instr_seq_ctrl: MEM_LAT out of range 1..15");
  end
  if (WDOG_CYCLES < 1 || WDOG_CYCLES > 255) begin : g_bad_wdog
    $error("instr_seq_ctrl: WDOG_CYCLES out of range 1..255");
  end

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StFetch   = 4'd1;
  localparam logic [3:0] StWait    = 4'd2;
  localparam logic [3:0] StDecode  = 4'd3;
  localparam logic [3:0] StFetchOp = 4'd4;
  localparam logic [3:0] StWaitOp  = 4'd5;
  localparam logic [3:0] StJump    = 4'd6;
  localparam logic [3:0] StExec    = 4'd7;
  localparam logic [3:0] StHalt    = 4'd8;

  localparam logic [3:0] LatLast = 4'(MEM_LAT - 1);

  logic [3:0] state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] target_q, target_d;
  logic [3:0] lat_cnt_q, lat_cnt_d;
  logic       fault_q, fault_d;

  logic [3:0] opcode;
  logic       last_beat;
  logic       taken;

  assign opcode    = ir_q[7:4];
  assign last_beat = (lat_cnt_q == LatLast);
  assign taken     = (opcode == 4'h8) | ((opcode == 4'h9) & zero_flag);

`ifdef SEQ_WATCHDOG_EN
  localparam logic [7:0] WdogLast = 8'(WDOG_CYCLES - 1);
  logic [7:0] wdog_cnt_q, wdog_cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    target_d      = target_q;
    lat_cnt_d     = '0;
    fault_d       = fault_q;
    mem_rd        = 1'b0;
    pc_en         = 1'b0;
    pc_load       = 1'b0;
    pc_load_value = 8'h00;
    exec_valid    = 1'b0;
    halted        = 1'b0;
`ifdef SEQ_WATCHDOG_EN
    wdog_cnt_d    = wdog_cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        mem_rd  = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        // Latch the opcode and step the PC only on the final latency cycle.
        if (last_beat) begin
          ir_d    = mem_rdata;
          pc_en   = 1'b1;
          state_d = StDecode;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      StDecode: begin
        unique case (opcode)
          4'h0:       state_d = StFetch;
          4'hF:       state_d = StHalt;
          4'h8, 4'h9: state_d = StFetchOp;
          default: begin
            state_d = StExec;
`ifdef SEQ_WATCHDOG_EN
            wdog_cnt_d = '0;
`endif
          end
        endcase
      end
      StFetchOp: begin
        mem_rd  = 1'b1;
        state_d = StWaitOp;
      end
      StWaitOp: begin
        // Stepping past the operand here means a not-taken jump needs no PC action.
        if (last_beat) begin
          target_d = mem_rdata;
          pc_en    = 1'b1;
          state_d  = StJump;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      StJump: begin
        if (taken) begin
          pc_en         = 1'b1;
          pc_load       = 1'b1;
          pc_load_value = target_q;
        end
        state_d = StFetch;
      end
      StExec: begin
        exec_valid = 1'b1;
        if (exec_ready) begin
          state_d = StFetch;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (wdog_cnt_q == WdogLast) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end else begin
          wdog_cnt_d = wdog_cnt_q + 8'd1;
        end
`endif
      end
      StHalt: begin
        halted = 1'b1;
        // A watchdog fault locks the sequencer in HALT until reset.
        if (start && !fault_q) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ir_q      <= 8'h00;
      target_q  <= 8'h00;
      lat_cnt_q <= 4'd0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      target_q  <= target_d;
      lat_cnt_q <= lat_cnt_d;
      fault_q   <= fault_d;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_cnt_q <= 8'd0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign ir = ir_q;

endmodule
